// File: rtl/apu_pkg.sv
// ----------------------------------------------------------------------------
// apu_pkg
// Definitions shared by the APU sound path (scheduler and tone generator):
//   - 2-bit voice codes (none / eat / hit / die)
//   - scheduler state encoding
//   - default frame lengths of each sound and of the inter-sound gap
//   - helper converting a voice code to its one-hot request bit {die,hit,eat}
// No ports (package).
// ----------------------------------------------------------------------------
package apu_pkg;

    localparam int FRAME_W_DEF    = 5;
    localparam int EAT_FRAMES_DEF = 8;
    localparam int HIT_FRAMES_DEF = 12;
    localparam int DIE_FRAMES_DEF = 30;
    localparam int GAP_FRAMES_DEF = 1;

    typedef enum logic [1:0] {
        VOICE_NONE = 2'd0,
        VOICE_EAT  = 2'd1,
        VOICE_HIT  = 2'd2,
        VOICE_DIE  = 2'd3
    } voice_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // One-hot request bit owned by a voice, in {die, hit, eat} order.
    function automatic logic [2:0] voice_mask(input voice_e v);
        logic [2:0] m;
        case (v)
            VOICE_EAT: m = 3'b001;
            VOICE_HIT: m = 3'b010;
            VOICE_DIE: m = 3'b100;
            default:   m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/apu_sound_scheduler_if.sv
// ----------------------------------------------------------------------------
// apu_sound_scheduler_if
// Bundle between the trigger stage / tone generator and the sound scheduler.
//   frame_end, enable, eat_req, hit_req, die_req : towards the scheduler
//   voice_sel, voice_active, sound_start, pending: from the scheduler
// master: the side that raises requests and watches the voice.
// slave : the scheduler itself.
// ----------------------------------------------------------------------------
interface apu_sound_scheduler_if;
    logic       frame_end;
    logic       enable;
    logic       eat_req;
    logic       hit_req;
    logic       die_req;
    logic [1:0] voice_sel;
    logic       voice_active;
    logic       sound_start;
    logic [2:0] pending;

    modport master (
        output frame_end, enable, eat_req, hit_req, die_req,
        input  voice_sel, voice_active, sound_start, pending
    );

    modport slave (
        input  frame_end, enable, eat_req, hit_req, die_req,
        output voice_sel, voice_active, sound_start, pending
    );
endinterface

// File: rtl/sound_req_edge.sv
// ----------------------------------------------------------------------------
// sound_req_edge
// 3-bit rising-edge detector for the level sound requests.
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   i_req in  level requests {die, hit, eat}
//   o_new out one cycle high per rising edge of each request
// The delayed copy keeps tracking while the scheduler is muted, so a request
// already high when sound is re-enabled does not produce an edge.
// ----------------------------------------------------------------------------
module sound_req_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_req,
    output logic [2:0] o_new
);
    logic [2:0] r_req_q;

    // Delayed copy of the requests for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_q <= 3'b000;
        end else begin
            r_req_q <= i_req;
        end
    end

    assign o_new = i_req & ~r_req_q;
endmodule

// File: rtl/apu_sound_scheduler.sv
// ----------------------------------------------------------------------------
// apu_sound_scheduler
// Shares the single APU voice between the eat, hit and die sounds.
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   sched     apu_sound_scheduler_if.slave:
//     frame_end/enable/eat_req/hit_req/die_req in,
//     voice_sel/voice_active/sound_start/pending out (all registered)
// Request edges are queued as pending bits; the highest of (pending | new)
// wins (die > hit > eat). Each sound lasts its frame count of frame_end
// pulses after the start, followed by GAP_FRAMES silent frames.
// ----------------------------------------------------------------------------
module apu_sound_scheduler
    import apu_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int EAT_FRAMES = EAT_FRAMES_DEF,
    parameter int HIT_FRAMES = HIT_FRAMES_DEF,
    parameter int DIE_FRAMES = DIE_FRAMES_DEF,
    parameter int GAP_FRAMES = GAP_FRAMES_DEF
) (
    input logic                   clk,
    input logic                   reset,
    apu_sound_scheduler_if.slave  sched
);
    state_e               r_state;
    voice_e               r_voice_sel;
    logic                 r_voice_active;
    logic                 r_sound_start;
    logic [2:0]           r_pending;
    logic [FRAME_W-1:0]   r_count;

    logic [2:0]           w_req;
    logic [2:0]           w_new;
    logic [2:0]           w_cand;
    logic [2:0]           w_cur_bit;
    voice_e               w_win;
    voice_e               w_new_top;
    logic                 w_last_frame;
    logic                 w_start;

    // Highest-priority voice present in a {die, hit, eat} request vector.
    function automatic voice_e f_prio(input logic [2:0] v);
        voice_e r;
        if (v[2]) begin
            r = VOICE_DIE;
        end else if (v[1]) begin
            r = VOICE_HIT;
        end else if (v[0]) begin
            r = VOICE_EAT;
        end else begin
            r = VOICE_NONE;
        end
        return r;
    endfunction

    // Length in frames of a voice.
    function automatic logic [FRAME_W-1:0] f_frames(input voice_e v);
        logic [FRAME_W-1:0] n;
        case (v)
            VOICE_EAT: n = FRAME_W'(EAT_FRAMES);
            VOICE_HIT: n = FRAME_W'(HIT_FRAMES);
            VOICE_DIE: n = FRAME_W'(DIE_FRAMES);
            default:   n = {FRAME_W{1'b0}};
        endcase
        return n;
    endfunction

    assign w_req = {sched.die_req, sched.hit_req, sched.eat_req};

    sound_req_edge u_edge (
        .clk   (clk),
        .reset (reset),
        .i_req (w_req),
        .o_new (w_new)
    );

    assign w_cand       = r_pending | w_new;
    assign w_win        = f_prio(w_cand);
    assign w_new_top    = f_prio(w_new);
    assign w_cur_bit    = voice_mask(r_voice_sel);
    assign w_last_frame = sched.frame_end && (r_count == FRAME_W'(1));

    // Decide whether this cycle (re)starts the winner with a fresh counter.
    // Pending bits are always below the playing voice, so a preempting edge
    // is always the overall winner.
    always_comb begin
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: w_start = (w_cand != 3'b000);
            ST_PLAY: w_start = (w_new_top > r_voice_sel) ||
                               (w_last_frame && (GAP_FRAMES == 0) && (w_cand != 3'b000));
            ST_GAP:  w_start = w_last_frame && (w_cand != 3'b000);
            default: w_start = 1'b0;
        endcase
    end

    // Scheduler FSM with its counter, pending queue and registered outputs.
    always_ff @(posedge clk) begin
        if (reset || !sched.enable) begin
            r_state        <= ST_IDLE;
            r_voice_sel    <= VOICE_NONE;
            r_voice_active <= 1'b0;
            r_sound_start  <= 1'b0;
            r_pending      <= 3'b000;
            r_count        <= {FRAME_W{1'b0}};
        end else if (w_start) begin
            r_state        <= ST_PLAY;
            r_voice_sel    <= w_win;
            r_voice_active <= 1'b1;
            r_sound_start  <= 1'b1;
            r_pending      <= w_cand & ~voice_mask(w_win);
            r_count        <= f_frames(w_win);
        end else begin
            r_sound_start <= 1'b0;
            r_pending     <= w_cand & ~w_cur_bit;
            case (r_state)
                ST_PLAY: begin
                    if ((w_new & w_cur_bit) != 3'b000) begin
                        // Retrigger of the playing voice.
                        r_count       <= f_frames(r_voice_sel);
                        r_sound_start <= 1'b1;
                    end else if (w_last_frame) begin
                        r_voice_sel    <= VOICE_NONE;
                        r_voice_active <= 1'b0;
                        if (GAP_FRAMES != 0) begin
                            r_state <= ST_GAP;
                            r_count <= FRAME_W'(GAP_FRAMES);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (sched.frame_end) begin
                        r_count <= r_count - FRAME_W'(1);
                    end else begin
                        r_count <= r_count;
                    end
                end
                ST_GAP: begin
                    if (w_last_frame) begin
                        r_state <= ST_IDLE;
                    end else if (sched.frame_end) begin
                        r_count <= r_count - FRAME_W'(1);
                    end else begin
                        r_count <= r_count;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sched.voice_sel    = r_voice_sel;
    assign sched.voice_active = r_voice_active;
    assign sched.sound_start  = r_sound_start;
    assign sched.pending      = r_pending;
endmodule
